// File: rtl/mips_cpu_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/exec/mem/wb.
// Drives ALU op, operand selects and PC/memory/register strobes.
//
// Ports:
//   i_clk             rising-edge clock
//   i_rst_n           asynchronous active-low reset
//   i_mem_readdata    memory read data, loaded into IR at fetch completion
//   i_mem_waitrequest memory stall, current access held while high
//   i_alu_zero        ALU zero flag for the current cycle
//   o_instr           instruction register
//   o_alu_op          0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLTU, 5 XOR
//   o_alu_src_a       0 PC, 1 rs
//   o_alu_src_b       0 rt, 1 const 4, 2 simm16, 3 zimm16
//   o_pc_write        PC load enable
//   o_pc_src          0 ALU, 1 branch target, 2 jump target, 3 rs
//   o_i_or_d          memory address select, 0 PC, 1 ALUOut
//   o_mem_read        memory read strobe
//   o_mem_write       memory write strobe
//   o_reg_write       register file write enable
//   o_reg_dst         0 rt, 1 rd
//   o_mem_to_reg      0 ALUOut, 1 memory data
//   o_active          high unless halted, idle or in reset

module mips_cpu_ctrl_fsm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_mem_readdata,
    input  logic        i_mem_waitrequest,
    input  logic        i_alu_zero,
    output logic [31:0] o_instr,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_src,
    output logic        o_i_or_d,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_reg_write,
    output logic        o_reg_dst,
    output logic        o_mem_to_reg,
    output logic        o_active
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SIMM = 2'd2;
    localparam logic [1:0] SRCB_ZIMM = 2'd3;

    localparam logic [1:0] PCS_ALU  = 2'd0;
    localparam logic [1:0] PCS_BR   = 2'd1;
    localparam logic [1:0] PCS_JMP  = 2'd2;
    localparam logic [1:0] PCS_RS   = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_r;
    logic        w_r_fn_ok;
    logic [3:0]  w_r_op;
    logic        w_i_ok;
    logic [3:0]  w_i_op;
    logic [1:0]  w_i_srcb;

    logic        w_r_alu;
    logic        w_jr;
    logic        w_i_alu;
    logic        w_lw;
    logic        w_sw;
    logic        w_beq;
    logic        w_bne;
    logic        w_j;
    logic        w_ir_load;

    assign w_opcode = r_instr[31:26];
    assign w_funct  = r_instr[5:0];
    assign w_is_r   = (w_opcode == OP_RTYPE);

    // R-type funct to ALU op
    always_comb begin
        w_r_fn_ok = 1'b1;
        w_r_op    = ALU_ADD;
        case (w_funct)
            FN_ADDU: w_r_op = ALU_ADD;
            FN_SUBU: w_r_op = ALU_SUB;
            FN_AND:  w_r_op = ALU_AND;
            FN_OR:   w_r_op = ALU_OR;
            FN_XOR:  w_r_op = ALU_XOR;
            FN_SLTU: w_r_op = ALU_SLTU;
            default: w_r_fn_ok = 1'b0;
        endcase
    end

    // I-type opcode to ALU op and immediate extension
    always_comb begin
        w_i_ok   = 1'b1;
        w_i_op   = ALU_ADD;
        w_i_srcb = SRCB_ZIMM;
        case (w_opcode)
            OP_ADDIU: begin
                w_i_op   = ALU_ADD;
                w_i_srcb = SRCB_SIMM;
            end
            OP_SLTIU: begin
                w_i_op   = ALU_SLTU;
                w_i_srcb = SRCB_SIMM;
            end
            OP_ANDI: w_i_op = ALU_AND;
            OP_ORI:  w_i_op = ALU_OR;
            OP_XORI: w_i_op = ALU_XOR;
            default: w_i_ok = 1'b0;
        endcase
    end

    assign w_r_alu = w_is_r && w_r_fn_ok;
    assign w_jr    = w_is_r && (w_funct == FN_JR);
    assign w_i_alu = w_i_ok;
    assign w_lw    = (w_opcode == OP_LW);
    assign w_sw    = (w_opcode == OP_SW);
    assign w_beq   = (w_opcode == OP_BEQ);
    assign w_bne   = (w_opcode == OP_BNE);
    assign w_j     = (w_opcode == OP_J);

    assign w_ir_load = (r_state == S_FETCH) && !i_mem_waitrequest;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (w_ir_load) begin
                r_instr <= i_mem_readdata;
            end
        end
    end

    assign o_instr = r_instr;

    // Outputs decode straight from state so that reset drops every
    // strobe immediately and branches see the same-cycle zero flag.
    always_comb begin
        w_next       = r_state;
        o_alu_op     = ALU_AND;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_RT;
        o_pc_write   = 1'b0;
        o_pc_src     = PCS_ALU;
        o_i_or_d     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_active     = 1'b1;

        case (r_state)
            S_IDLE: begin
                o_active = 1'b0;
                w_next   = S_FETCH;
            end

            S_FETCH: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b0;
                if (!i_mem_waitrequest) begin
                    o_alu_src_a = 1'b0;
                    o_alu_src_b = SRCB_FOUR;
                    o_alu_op    = ALU_ADD;
                    o_pc_src    = PCS_ALU;
                    o_pc_write  = 1'b1;
                    w_next      = S_DECODE;
                end
            end

            S_DECODE: begin
                w_next = S_EXEC;
            end

            S_EXEC: begin
                w_next = S_FETCH;
                unique case (1'b1)
                    w_r_alu: begin
                        o_alu_op    = w_r_op;
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_RT;
                        w_next      = S_WB;
                    end
                    w_jr: begin
                        o_alu_op    = ALU_OR;
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_RT;
                        // A jump to address zero is the halt request
                        if (i_alu_zero) begin
                            w_next = S_HALT;
                        end else begin
                            o_pc_src   = PCS_RS;
                            o_pc_write = 1'b1;
                        end
                    end
                    w_i_alu: begin
                        o_alu_op    = w_i_op;
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = w_i_srcb;
                        w_next      = S_WB;
                    end
                    (w_lw || w_sw): begin
                        o_alu_op    = ALU_ADD;
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_SIMM;
                        w_next      = S_MEM;
                    end
                    (w_beq || w_bne): begin
                        o_alu_op    = ALU_SUB;
                        o_alu_src_a = 1'b1;
                        o_alu_src_b = SRCB_RT;
                        o_pc_src    = PCS_BR;
                        o_pc_write  = w_beq ? i_alu_zero : !i_alu_zero;
                    end
                    w_j: begin
                        o_pc_src   = PCS_JMP;
                        o_pc_write = 1'b1;
                    end
                    default: begin
                        w_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                o_i_or_d    = 1'b1;
                o_mem_read  = w_lw;
                o_mem_write = w_sw;
                if (!i_mem_waitrequest) begin
                    w_next = w_lw ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = w_is_r;
                o_mem_to_reg = w_lw;
                w_next       = S_FETCH;
            end

            S_HALT: begin
                o_active = 1'b0;
                w_next   = S_HALT;
            end

            default: begin
                o_active = 1'b0;
                w_next   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// Scoreboard bench for mips_cpu_ctrl_fsm: an instruction-level model
// queues per-cycle expectations, a negedge monitor compares them.

module tb_mips_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rd;
    logic        wr;
    logic        z;

    logic [31:0] o_instr;
    logic [3:0]  o_alu_op;
    logic        o_alu_src_a;
    logic [1:0]  o_alu_src_b;
    logic        o_pc_write;
    logic [1:0]  o_pc_src;
    logic        o_i_or_d;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_reg_write;
    logic        o_reg_dst;
    logic        o_mem_to_reg;
    logic        o_active;

    always #5 clk = ~clk;

    mips_cpu_ctrl_fsm dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_mem_readdata    (rd),
        .i_mem_waitrequest (wr),
        .i_alu_zero        (z),
        .o_instr           (o_instr),
        .o_alu_op          (o_alu_op),
        .o_alu_src_a       (o_alu_src_a),
        .o_alu_src_b       (o_alu_src_b),
        .o_pc_write        (o_pc_write),
        .o_pc_src          (o_pc_src),
        .o_i_or_d          (o_i_or_d),
        .o_mem_read        (o_mem_read),
        .o_mem_write       (o_mem_write),
        .o_reg_write       (o_reg_write),
        .o_reg_dst         (o_reg_dst),
        .o_mem_to_reg      (o_mem_to_reg),
        .o_active          (o_active)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  alu_op;
        logic        src_a;
        logic [1:0]  src_b;
        logic [1:0]  pc_src;
        logic        i_or_d;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        pc_write;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        active;
    } obs_t;

    localparam int C_RALU = 0;
    localparam int C_IALU = 1;
    localparam int C_LW   = 2;
    localparam int C_SW   = 3;
    localparam int C_BEQ  = 4;
    localparam int C_BNE  = 5;
    localparam int C_J    = 6;
    localparam int C_JR   = 7;
    localparam int C_NOP  = 8;

    obs_t        eq[$];
    obs_t        mq[$];
    string       tq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_ir;

    function automatic obs_t sample();
        obs_t o;
        o.instr      = o_instr;
        o.alu_op     = o_alu_op;
        o.src_a      = o_alu_src_a;
        o.src_b      = o_alu_src_b;
        o.pc_src     = o_pc_src;
        o.i_or_d     = o_i_or_d;
        o.reg_dst    = o_reg_dst;
        o.mem_to_reg = o_mem_to_reg;
        o.pc_write   = o_pc_write;
        o.mem_read   = o_mem_read;
        o.mem_write  = o_mem_write;
        o.reg_write  = o_reg_write;
        o.active     = o_active;
        return o;
    endfunction

    // Monitor: strobe exclusivity every cycle, plus queued expectations
    always @(negedge clk) begin
        obs_t  a;
        obs_t  e;
        obs_t  m;
        string t;
        a = sample();
        checks++;
        if (int'(a.pc_write) + int'(a.mem_write) + int'(a.reg_write) > 1) begin
            errors++;
            $display("FAIL excl: pc_write=%0b mem_write=%0b reg_write=%0b, at most one allowed",
                     a.pc_write, a.mem_write, a.reg_write);
        end
        if (eq.size() != 0) begin
            e = eq.pop_front();
            m = mq.pop_front();
            t = tq.pop_front();
            checks++;
            if (((a ^ e) & m) != '0) begin
                errors++;
                $display("FAIL %s @%0t: got=%h exp=%h care=%h", t, $time, a, e, m);
            end
        end
    end

    function automatic logic rz();
        return ($urandom_range(0, 1) != 0);
    endfunction

    function automatic int cls(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2B}) return C_RALU;
            if (fn == 6'h08) return C_JR;
            return C_NOP;
        end
        if (op inside {6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) return C_IALU;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h05) return C_BNE;
        if (op == 6'h02) return C_J;
        return C_NOP;
    endfunction

    function automatic logic [3:0] r_op(input logic [5:0] f);
        case (f)
            6'h21:   return 4'd2;
            6'h23:   return 4'd3;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h26:   return 4'd5;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] i_op(input logic [5:0] op);
        case (op)
            6'h09:   return 4'd2;
            6'h0B:   return 4'd4;
            6'h0C:   return 4'd0;
            6'h0D:   return 4'd1;
            default: return 4'd5;
        endcase
    endfunction

    function automatic obs_t base(input logic act);
        obs_t o;
        o        = '0;
        o.instr  = cur_ir;
        o.active = act;
        return o;
    endfunction

    function automatic obs_t mbase();
        obs_t o;
        o           = '0;
        o.instr     = '1;
        o.pc_write  = 1'b1;
        o.mem_read  = 1'b1;
        o.mem_write = 1'b1;
        o.reg_write = 1'b1;
        o.active    = 1'b1;
        return o;
    endfunction

    task automatic step(input obs_t e, input obs_t m, input string t,
                        input logic r, input logic w, input logic [31:0] d,
                        input logic zz);
        @(posedge clk);
        #1;
        rst_n = r;
        wr    = w;
        rd    = d;
        z     = zz;
        eq.push_back(e);
        mq.push_back(m);
        tq.push_back(t);
    endtask

    task automatic do_reset(input int n);
        obs_t e;
        obs_t m;
        for (int i = 0; i < n; i++) begin
            e = '0;
            m = '1;
            step(e, m, "reset", 1'b0, rz(), $urandom, rz());
        end
        cur_ir = '0;
        e = base(1'b0);
        m = mbase();
        step(e, m, "idle", 1'b1, rz(), $urandom, rz());
    endtask

    task automatic halt_cycles(input int n);
        obs_t e;
        obs_t m;
        for (int i = 0; i < n; i++) begin
            e = base(1'b0);
            m = mbase();
            step(e, m, "halt", 1'b1, rz(), $urandom, rz());
        end
    endtask

    // One instruction from fetch to retirement.  stop=1 means the core
    // halted or was reset, and the caller must reset it.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                             input logic zx, input bit rst_mem, output bit stop);
        obs_t e;
        obs_t m;
        int   c;
        c    = cls(w);
        stop = 1'b0;

        for (int i = 0; i < fw; i++) begin
            e = base(1'b1);
            m = mbase();
            e.mem_read = 1'b1;
            m.i_or_d   = 1'b1;
            step(e, m, "fetch_stall", 1'b1, 1'b1, $urandom, rz());
        end
        e = base(1'b1);
        m = mbase();
        e.mem_read = 1'b1;
        e.pc_write = 1'b1;
        e.alu_op   = 4'd2;
        e.src_b    = 2'd1;
        m.i_or_d   = 1'b1;
        m.alu_op   = '1;
        m.src_a    = 1'b1;
        m.src_b    = '1;
        m.pc_src   = '1;
        step(e, m, "fetch", 1'b1, 1'b0, w, rz());
        cur_ir = w;

        e = base(1'b1);
        m = mbase();
        step(e, m, "decode", 1'b1, rz(), $urandom, rz());

        e = base(1'b1);
        m = mbase();
        case (c)
            C_RALU: begin
                e.alu_op = r_op(w[5:0]);
                e.src_a  = 1'b1;
                m.alu_op = '1;
                m.src_a  = 1'b1;
                m.src_b  = '1;
            end
            C_IALU: begin
                e.alu_op = i_op(w[31:26]);
                e.src_b  = (w[31:26] inside {6'h09, 6'h0B}) ? 2'd2 : 2'd3;
                m.alu_op = '1;
                m.src_b  = '1;
            end
            C_LW, C_SW: begin
                e.alu_op = 4'd2;
                e.src_a  = 1'b1;
                e.src_b  = 2'd2;
                m.alu_op = '1;
                m.src_a  = 1'b1;
                m.src_b  = '1;
            end
            C_BEQ, C_BNE: begin
                e.alu_op   = 4'd3;
                e.src_a    = 1'b1;
                e.pc_src   = 2'd1;
                e.pc_write = (c == C_BEQ) ? zx : !zx;
                m.alu_op   = '1;
                m.src_a    = 1'b1;
                m.src_b    = '1;
                m.pc_src   = '1;
            end
            C_J: begin
                e.pc_src   = 2'd2;
                e.pc_write = 1'b1;
                m.pc_src   = '1;
            end
            C_JR: begin
                e.alu_op = 4'd1;
                e.src_a  = 1'b1;
                m.alu_op = '1;
                m.src_a  = 1'b1;
                m.src_b  = '1;
                if (!zx) begin
                    e.pc_src   = 2'd3;
                    e.pc_write = 1'b1;
                    m.pc_src   = '1;
                end
            end
            default: begin
            end
        endcase
        step(e, m, "exec", 1'b1, rz(), $urandom, zx);
        if (c == C_JR && zx) begin
            stop = 1'b1;
            return;
        end

        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i < mw; i++) begin
                e = base(1'b1);
                m = mbase();
                e.i_or_d    = 1'b1;
                e.mem_read  = (c == C_LW);
                e.mem_write = (c == C_SW);
                m.i_or_d    = 1'b1;
                step(e, m, "mem_stall", 1'b1, 1'b1, $urandom, rz());
                if (rst_mem) begin
                    @(negedge clk);
                    #1;
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({o_pc_write, o_mem_read, o_mem_write, o_reg_write,
                         o_active} != 5'b0 || o_instr != 32'h0) begin
                        errors++;
                        $display("FAIL async_rst: mem_write=%0b active=%0b instr=%h, need 0",
                                 o_mem_write, o_active, o_instr);
                    end
                    cur_ir = '0;
                    stop   = 1'b1;
                    return;
                end
            end
            e = base(1'b1);
            m = mbase();
            e.i_or_d    = 1'b1;
            e.mem_read  = (c == C_LW);
            e.mem_write = (c == C_SW);
            m.i_or_d    = 1'b1;
            step(e, m, "mem", 1'b1, 1'b0, $urandom, rz());
        end

        if (c == C_RALU || c == C_IALU || c == C_LW) begin
            e = base(1'b1);
            m = mbase();
            e.reg_write  = 1'b1;
            e.reg_dst    = (c == C_RALU);
            e.mem_to_reg = (c == C_LW);
            m.reg_dst    = 1'b1;
            m.mem_to_reg = 1'b1;
            step(e, m, "wb", 1'b1, rz(), $urandom, rz());
        end
    endtask

    function automatic logic [31:0] gen();
        logic [5:0]  rfn [0:5];
        logic [5:0]  iop [0:4];
        logic [5:0]  bad [0:3];
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rdr;
        logic [15:0] imm;
        int          k;
        rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2B};
        iop = '{6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
        bad = '{6'h3F, 6'h01, 6'h20, 6'h0F};
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rdr = 5'($urandom);
        imm = 16'($urandom);
        k   = $urandom_range(0, 9);
        case (k)
            0, 1:    return {6'h00, rs, rt, rdr, 5'd0, rfn[$urandom_range(0, 5)]};
            2:       return {6'h00, rs, 15'd0, 6'h08};
            3:       return {iop[$urandom_range(0, 4)], rs, rt, imm};
            4:       return {6'h23, rs, rt, imm};
            5:       return {6'h2B, rs, rt, imm};
            6:       return {6'h04, rs, rt, imm};
            7:       return {6'h05, rs, rt, imm};
            8:       return {6'h02, 26'($urandom)};
            default: begin
                if (rz()) return {6'h00, rs, rt, rdr, 5'd0, 6'h00};
                return {bad[$urandom_range(0, 3)], rs, rt, imm};
            end
        endcase
    endfunction

    initial begin
        bit stop;
        rst_n  = 1'b0;
        wr     = 1'b0;
        rd     = '0;
        z      = 1'b0;
        cur_ir = '0;

        do_reset(2);

        run_instr(32'h00221821, 0, 0, 1'b0, 1'b0, stop);
        run_instr(32'h10220003, 0, 0, 1'b1, 1'b0, stop);
        run_instr(32'h10220003, 0, 0, 1'b0, 1'b0, stop);
        run_instr(32'h8C220004, 0, 2, 1'b0, 1'b0, stop);
        run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0, stop);
        run_instr(32'h03E00008, 1, 0, 1'b1, 1'b0, stop);
        halt_cycles(20);
        do_reset(1);
        run_instr(32'hAC220008, 1, 2, 1'b0, 1'b1, stop);
        do_reset(2);

        for (int n = 0; n < 300; n++) begin
            run_instr(gen(), $urandom_range(0, 2), $urandom_range(0, 2),
                      rz(), 1'b0, stop);
            if (stop) begin
                halt_cycles($urandom_range(1, 3));
                do_reset($urandom_range(1, 2));
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, need 0", eq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_ctrl_fsm.md
# mips_cpu_ctrl_fsm

Multi-cycle control sequencer that drives the datapath ALU: it decodes the latched instruction and issues the ALU op code, operand selects, and register/PC/memory strobes. It also consumes the ALU `zero` flag for branch and halt decisions. The block sits between the instruction memory port and the datapath, with one instruction in flight and no delay slots. Outputs are combinational from the state register, the instruction register, and the `alu_zero`/`mem_waitrequest` inputs.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_readdata` in 32: memory read data, captured into the IR at fetch completion.
- `mem_waitrequest` in 1: memory stall; the current access is held while high.
- `alu_zero` in 1: ALU zero flag for the current cycle's operation.
- `instr` out 32: instruction register.
- `alu_op` out 4: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (unsigned), 5 XOR.
- `alu_src_a` out 1: 0 = PC, 1 = rs data.
- `alu_src_b` out 2: 0 = rt data, 1 = constant 4, 2 = sign-extended imm16, 3 = zero-extended imm16.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: 0 = ALU result, 1 = branch target (PC + (simm << 2)), 2 = jump target, 3 = rs data.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back select; 0 = ALUOut, 1 = memory data.
- `active` out 1: high unless halted or in reset.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:** reset state. All strobes are 0 and `active` = 0. The state moves unconditionally to FETCH on the next edge.
- **FETCH:** drives `mem_read` = 1 and `i_or_d` = 0.
  - While `mem_waitrequest` = 1: the state holds, and `pc_write` and the IR load are suppressed.
  - When `mem_waitrequest` = 0: the IR loads `mem_readdata`. The block also drives `alu_src_a` = 0, `alu_src_b` = 1, `alu_op` = 2, `pc_src` = 0, `pc_write` = 1, and moves to DECODE.
- **DECODE:** one cycle for the register file read. No strobes are asserted. Next state is EXEC.
- **EXEC, R-type ALU** (funct 0x21 ADDU→2, 0x23 SUBU→3, 0x24 AND→0, 0x25 OR→1, 0x26 XOR→5, 0x2B SLTU→4): `alu_src_a` = 1, `alu_src_b` = 0. Next state is WB.
- **EXEC, I-type ALU** (opcode 0x09 ADDIU→2 with src_b = 2, 0x0B SLTIU→4 with src_b = 2, 0x0C ANDI→0, 0x0D ORI→1, 0x0E XORI→5, the last three with src_b = 3). Next state is WB.
- **EXEC, LW (0x23) / SW (0x2B):** `alu_op` = 2, `alu_src_a` = 1, `alu_src_b` = 2. Next state is MEM.
- **EXEC, BEQ (0x04) / BNE (0x05):** `alu_op` = 3, `alu_src_a` = 1, `alu_src_b` = 0, `pc_src` = 1.
  - `pc_write` = `alu_zero` for BEQ, `!alu_zero` for BNE.
  - Next state is FETCH.
- **EXEC, J (0x02):** `pc_src` = 2, `pc_write` = 1. Next state is FETCH.
- **EXEC, JR (R-type, funct 0x08):** `alu_op` = 1, `alu_src_a` = 1, `alu_src_b` = 0; the result is rs | $0.
  - If `alu_zero` = 1: next state is HALT and `pc_write` = 0.
  - Otherwise: `pc_src` = 3, `pc_write` = 1, next state is FETCH.
- **MEM:** `i_or_d` = 1; `mem_read` for LW, `mem_write` for SW.
  - The state holds while `mem_waitrequest` = 1.
  - On completion, SW goes to FETCH and LW goes to WB.
- **WB:** `reg_write` = 1 for exactly one cycle.
  - R-type: `reg_dst` = 1. I-type and LW: `reg_dst` = 0.
  - `mem_to_reg` = 1 only for LW.
  - Next state is FETCH.
- **Unsupported opcode or funct:** treated as a NOP. EXEC asserts no strobes and returns to FETCH.
- **HALT:** terminal state with all strobes 0 and `active` = 0. Only reset exits it.
- **Datapath dependency:** the external ALUOut and memory-data registers load every cycle. The block relies on this for MEM and WB.

## Timing
- **Reset values:** all outputs 0 and `instr` = 0. Reset is asynchronous: asserting `rst_n` mid-instruction, including mid-MEM with a stall active, forces IDLE immediately and drops all strobes the same cycle.
- **Cycle counts with zero wait states:**
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch, J, JR: 3 cycles.
  - Each wait cycle adds 1.
- **Strobe hold during stalls:** `mem_read` and `mem_write` stay asserted, with address selects stable, for every stalled cycle.
- **Branch timing:** the decision uses the `alu_zero` value from the same EXEC cycle.
- **Strobe exclusivity:** `reg_write`, `pc_write`, and `mem_write` are never asserted in the same cycle.
- **Active after reset:** `active` rises on the first FETCH cycle after reset release.

## Test plan
- **ADDU:** reset, then fetch ADDU $3,$1,$2 (0x00221821) with no waits.
  - Required: `pc_write` = 1 in FETCH.
  - EXEC: `alu_op` = 2, `alu_src_b` = 0.
  - WB: `reg_write` = 1, `reg_dst` = 1, on cycle 4.
- **BEQ:** fetch BEQ $1,$2,+3 (0x10220003).
  - With `alu_zero` = 1 in EXEC: `pc_write` = 1 and `pc_src` = 1.
  - Rerun with `alu_zero` = 0: `pc_write` = 0. Both cases return to FETCH.
- **LW with stalls:** LW (0x8C220004) with `mem_waitrequest` high for 2 MEM cycles.
  - Required: `mem_read` = 1 and `i_or_d` = 1 for 3 cycles.
  - Then WB with `mem_to_reg` = 1 and `reg_dst` = 0. Total 7 cycles.
- **JR to zero:** JR $31 (0x03E00008) with `alu_zero` = 1.
  - Required: HALT state, `active` = 0, all strobes 0 for 20 further cycles.
- **Reset mid-access:** assert `rst_n` low during a stalled SW MEM cycle.
  - Required: `mem_write` drops without waiting for a clock edge.
  - After release: 1 IDLE cycle, then FETCH.
- **Unsupported opcode:** opcode 0x3F.
  - Required: no `reg_write`, `mem_write`, or `pc_write` in EXEC. Next FETCH occurs 3 cycles after the first.
